if_fetch_unit: RTL and testbench

Instruction-fetch front end that produces the `IF_Instr` / `IF_PC` / `IF_ExceptType` stream consumed by the IF/ID pipeline register.
- Owns the PC and issues fetches on the sram-like instruction port, one outstanding request at a time.
- Buffers returned words in a small FIFO so that ID stalls (`ID_Wr`=0) never lose an instruction.
- Handles redirects from branch/exception logic, including discarding an in-flight response.

---
 rtl/if_fetch_unit_pkg.sv | 30 +++
 rtl/if_fetch_unit_fifo.sv | 72 +++++++
 rtl/if_fetch_unit.sv | 107 ++++++++++
 tb/tb_if_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared CPU fetch definitions: pipeline exception bits, fetch FIFO entry, reset vector.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic Interrupt;
        logic FetchAddr;
        logic ReservedInst;
        logic Syscall;
        logic Break;
        logic Overflow;
        logic Eret;
    } ExceptinPipeType;

    typedef struct packed {
        logic [31:0]     instr;
        logic [31:0]     pc;
        ExceptinPipeType except;
    } fetch_entry_t;

    function automatic fetch_entry_t fetch_fault(input logic [31:0] pc);
        fetch_entry_t e;
        e           = '0;
        e.pc        = pc;
        e.except.FetchAddr = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Circular fetch FIFO with clear; head reads as all-zero (nop bubble) when empty.
module fetch_fifo
    import if_fetch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         clear,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  count_q, count_d;
    logic           pop_en, push_en;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign pop_en  = pop && (count_q != '0);
    assign push_en = push && (!full || pop_en);
    assign count   = count_q;
    assign head    = (count_q == '0) ? '0 : mem_q[rd_q];

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (clear) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_en) begin
                mem_d[wr_q] = push_data;
                wr_d        = ptr_next(wr_q);
            end
            if (pop_en) begin
                rd_d = ptr_next(rd_q);
            end
            count_d = count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: PC ownership, single-outstanding sram-like fetch,
// redirect with in-flight discard, and a buffer that absorbs ID stalls.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Redirect_Valid,
    input  logic [31:0]     Redirect_PC,
    input  logic            ID_Wr,
    output logic            inst_req,
    output logic [31:0]     inst_addr,
    input  logic            inst_addr_ok,
    input  logic            inst_data_ok,
    input  logic [31:0]     inst_rdata,
    output logic [31:0]     IF_Instr,
    output logic [31:0]     IF_PC,
    output ExceptinPipeType IF_ExceptType
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d;
    logic          outstanding_q, outstanding_d;
    logic          discard_q, discard_d;
    logic          halted_q, halted_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_push;
    fetch_entry_t  fifo_head, fifo_data;
    logic [CW:0]   inflight;
    logic          aligned, accept, resp, misalign_push;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_data),
        .pop       (ID_Wr),
        .clear     (Redirect_Valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign IF_Instr      = fifo_head.instr;
    assign IF_PC         = fifo_head.pc;
    assign IF_ExceptType = fifo_head.except;
    assign inst_addr     = pc_q;

    // Issue reserves a FIFO slot for every in-flight word, so a response is never refused.
    always_comb begin
        inflight      = {1'b0, fifo_count} + (CW+1)'(outstanding_q);
        aligned       = (pc_q[1:0] == 2'b00);
        inst_req      = !halted_q && aligned && (inflight < (CW+1)'(DEPTH))
                        && (!outstanding_q || inst_data_ok);
        accept        = inst_req && inst_addr_ok;
        resp          = inst_data_ok && outstanding_q;
        misalign_push = !halted_q && !aligned && !fifo_full;
        fifo_push     = (resp && !discard_q) || misalign_push;
        fifo_data     = misalign_push ? fetch_fault(pc_q)
                                      : '{instr: inst_rdata, pc: req_pc_q, except: '0};

        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        halted_d      = halted_q;

        if (accept) begin
            outstanding_d = 1'b1;
            req_pc_d      = pc_q;
        end else if (resp) begin
            outstanding_d = 1'b0;
        end

        if (Redirect_Valid) begin
            pc_d      = Redirect_PC;
            halted_d  = 1'b0;
            discard_d = accept || (outstanding_q && !inst_data_ok) ;
        end else begin
            if (accept) pc_d = pc_q + 32'd4;
            if (resp && discard_q) discard_d = 1'b0;
            if (misalign_push) halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            halted_q      <= halted_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed plus randomized bench for if_fetch_unit against a queue-based fetch model.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            Redirect_Valid;
    logic [31:0]     Redirect_PC;
    logic            ID_Wr;
    logic            inst_req;
    logic [31:0]     inst_addr;
    logic            inst_addr_ok;
    logic            inst_data_ok;
    logic [31:0]     inst_rdata;
    logic [31:0]     IF_Instr;
    logic [31:0]     IF_PC;
    ExceptinPipeType IF_ExceptType;

    if_fetch_unit #(.RESET_PC(32'hBFC0_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .Redirect_Valid (Redirect_Valid),
        .Redirect_PC    (Redirect_PC),
        .ID_Wr          (ID_Wr),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .IF_Instr       (IF_Instr),
        .IF_PC          (IF_PC),
        .IF_ExceptType  (IF_ExceptType)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference fetch model: architectural PC, in-flight request, and the visible instruction queue.
    logic [31:0]  m_pc;
    logic [31:0]  m_req_pc;
    logic         m_out, m_disc, m_halt;
    fetch_entry_t m_q[$];
    logic [31:0]  mem_pend[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h9BC8_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'hBFC0_0000; m_req_pc = '0;
        m_out = 1'b0; m_disc = 1'b0; m_halt = 1'b0;
        m_q.delete(); mem_pend.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        Redirect_Valid = 1'b0; Redirect_PC = '0; ID_Wr = 1'b0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
        model_reset();
        #1;
        chk("rst_IF_Instr", IF_Instr, 32'h0);
        chk("rst_IF_PC", IF_PC, 32'h0);
        chk("rst_inst_addr", inst_addr, 32'hBFC0_0000);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock: drive inputs, check outputs mid-cycle against the model, then advance model.
    task automatic cycle(input logic redir, input logic [31:0] rpc, input logic idwr,
                         input logic aok, input logic dok);
        logic         exp_req, acc, resp;
        logic [31:0]  old_pc;
        int           sz;
        fetch_entry_t e;
        Redirect_Valid = redir; Redirect_PC = rpc; ID_Wr = idwr;
        inst_addr_ok = aok; inst_data_ok = dok;
        inst_rdata = (mem_pend.size() > 0) ? mem_word(mem_pend[0]) : $urandom;
        @(negedge clk);
        sz      = m_q.size();
        exp_req = !m_halt && (m_pc[1:0] == 2'b00) && (sz + int'(m_out) < DEPTH)
                  && (!m_out || dok);
        e       = (sz > 0) ? m_q[0] : '0;
        chk("inst_req", 32'(inst_req), 32'(exp_req));
        chk("inst_addr", inst_addr, m_pc);
        chk("IF_Instr", IF_Instr, e.instr);
        chk("IF_PC", IF_PC, e.pc);
        chk("IF_ExceptType", 32'(IF_ExceptType), 32'(e.except));

        acc    = exp_req && aok;
        resp   = m_out && dok;
        old_pc = m_pc;
        if (redir) begin
            m_q.delete();
            m_disc = acc || (m_out && !dok);
            m_pc   = rpc;
            m_halt = 1'b0;
        end else begin
            if (idwr && sz > 0) void'(m_q.pop_front());
            if (resp) begin
                if (m_disc) m_disc = 1'b0;
                else m_q.push_back('{instr: mem_word(m_req_pc), pc: m_req_pc, except: '0});
            end
            if (!m_halt && old_pc[1:0] != 2'b00 && sz < DEPTH) begin
                m_q.push_back(fetch_fault(old_pc));
                m_halt = 1'b1;
            end
            if (acc) m_pc = old_pc + 32'd4;
        end
        if (acc) begin
            m_out = 1'b1; m_req_pc = old_pc;
        end else if (resp) begin
            m_out = 1'b0;
        end
        if (dok && mem_pend.size() > 0) void'(mem_pend.pop_front());
        if (acc) mem_pend.push_back(old_pc);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        ExceptinPipeType fa;
        logic [31:0] r;
        fa = '0; fa.FetchAddr = 1'b1;

        // First fetch after reset, data one cycle after addr_ok.
        do_reset();
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 0, 1);
        chk("first_instr", IF_Instr, 32'h2408_0001);
        chk("first_pc", IF_PC, 32'hBFC0_0000);
        chk("second_addr", inst_addr, 32'hBFC0_0004);
        cycle(0, 0, 1, 1, 0);

        // Back-to-back stream with ID never stalling.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 1, 1);
        // ID stall fills the buffer; issue stops at DEPTH in flight.
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 1);
        chk("stall_req", 32'(inst_req), 32'h0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1, 1, 1);

        // Redirect while BFC0_0008 is outstanding.
        do_reset();
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(1, 32'h8000_0180, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("redir_empty", IF_PC, 32'h0);
        chk("redir_addr", inst_addr, 32'h8000_0180);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        chk("redir_first_pc", IF_PC, 32'h8000_0180);

        // Misaligned redirect halts fetch with a FetchAddr entry.
        cycle(1, 32'h8000_0002, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        chk("mis_pc", IF_PC, 32'h8000_0002);
        chk("mis_instr", IF_Instr, 32'h0);
        chk("mis_exc", 32'(IF_ExceptType), 32'(fa));
        chk("mis_req", 32'(inst_req), 32'h0);
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 1, 1, 0);
        cycle(1, 32'h8000_0000, 1, 1, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1, 1);

        // Reset mid-transaction followed by a stale response.
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 1, 0);
        do_reset();
        cycle(0, 0, 1, 0, 1);
        chk("stale_pc", IF_PC, 32'h0);
        chk("stale_addr", inst_addr, 32'hBFC0_0000);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1);
        chk("restart_pc", IF_PC, 32'hBFC0_0000);
        chk("restart_instr", IF_Instr, 32'h2408_0001);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            if ($urandom_range(0, 99) < 4) begin
                if ($urandom_range(0, 9) == 0) cycle(1, r, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                else cycle(1, {r[31:2], 2'b00}, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            end else begin
                cycle(0, 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
            end
            if (i == 300) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
